// File: rtl/ram_loader_if.sv
// Byte-stream and RAM-port bundle for ram_loader.
// master = loader side; slave = host link and RAM side.
interface ram_loader_if #(
    parameter int AWIDTH = 12
);
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic [7:0]        out_data;
    logic              out_valid;
    logic              out_ready;
    logic              ram_load;
    logic [AWIDTH-1:0] ram_addr;
    logic [15:0]       ram_d;
    logic [15:0]       ram_q;

    modport master (
        input  in_data, in_valid, out_ready, ram_q,
        output in_ready, out_data, out_valid, ram_load, ram_addr, ram_d
    );

    modport slave (
        output in_data, in_valid, out_ready, ram_q,
        input  in_ready, out_data, out_valid, ram_load, ram_addr, ram_d
    );
endinterface

// File: rtl/ram_loader.sv
// Byte-stream loader/dumper for the 16-bit program RAM; optional checksum under LOADER_CHECKSUM_EN.
// Latency: LOAD 3 cycles/word, DUMP 4 cycles/word minimum; done pulses one cycle after the last word.
// Backpressure: in_valid gaps stall in LD_HI/LD_LO; out_ready low holds out_data/out_valid in DP_HI/DP_LO.
module ram_loader #(
    parameter int DWIDTH = 16,
    parameter int AWIDTH = 12,
    parameter int WORDS  = 4096
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              mode,
    input  logic [AWIDTH-1:0] base,
    input  logic [AWIDTH:0]   count,
    output logic              busy,
    output logic              done,
    output logic [15:0]       checksum,
    ram_loader_if.master      bus
);

    typedef enum logic [3:0] {
        IDLE, LD_HI, LD_LO, LD_WR, DP_RD, DP_CAP, DP_HI, DP_LO, FIN
    } state_t;

    state_t              state_q, state_nxt;
    logic [AWIDTH-1:0]   ptr_q;
    logic [AWIDTH:0]     rem_q;
    logic [DWIDTH-1:0]   word_q;
    logic [AWIDTH-1:0]   ptr_inc;
    logic                last_word;

    assign ptr_inc   = (ptr_q == AWIDTH'(WORDS - 1)) ? '0 : ptr_q + 1'b1;
    assign last_word = (rem_q == (AWIDTH+1)'(1));

    assign bus.ram_addr = ptr_q;
    assign bus.ram_d    = word_q;

    always_comb begin
        state_nxt     = state_q;
        busy          = (state_q != IDLE);
        done          = 1'b0;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.out_data  = 8'h00;
        bus.ram_load  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (count == '0)  state_nxt = FIN;
                    else if (mode)    state_nxt = DP_RD;
                    else              state_nxt = LD_HI;
                end
            end
            LD_HI: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) state_nxt = LD_LO;
            end
            LD_LO: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) state_nxt = LD_WR;
            end
            LD_WR: begin
                bus.ram_load = 1'b1;
                state_nxt    = last_word ? FIN : LD_HI;
            end
            DP_RD:  state_nxt = DP_CAP;
            DP_CAP: state_nxt = DP_HI;
            DP_HI: begin
                bus.out_valid = 1'b1;
                bus.out_data  = word_q[15:8];
                if (bus.out_ready) state_nxt = DP_LO;
            end
            DP_LO: begin
                bus.out_valid = 1'b1;
                bus.out_data  = word_q[7:0];
                if (bus.out_ready) state_nxt = last_word ? FIN : DP_RD;
            end
            FIN: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            rem_q   <= '0;
            word_q  <= '0;
        end else begin
            state_q <= state_nxt;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        ptr_q <= base;
                        rem_q <= count;
                    end
                end
                LD_HI:  if (bus.in_valid) word_q[15:8] <= bus.in_data;
                LD_LO:  if (bus.in_valid) word_q[7:0]  <= bus.in_data;
                LD_WR: begin
                    ptr_q <= ptr_inc;
                    rem_q <= rem_q - 1'b1;
                end
                DP_CAP: word_q <= bus.ram_q;
                DP_LO: begin
                    if (bus.out_ready) begin
                        ptr_q <= ptr_inc;
                        rem_q <= rem_q - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef LOADER_CHECKSUM_EN
    logic [15:0] csum_q;

    // Accumulates the word as it is written (LD_WR) or as it arrives from the RAM (DP_CAP).
    always_ff @(posedge clk) begin
        if (reset) begin
            csum_q <= '0;
        end else if (state_q == IDLE && start) begin
            csum_q <= '0;
        end else if (state_q == LD_WR) begin
            csum_q <= csum_q + word_q;
        end else if (state_q == DP_CAP) begin
            csum_q <= csum_q + bus.ram_q;
        end
    end

    assign checksum = csum_q;
`else
    assign checksum = 16'h0000;
`endif

endmodule
